// File: rtl/vector_narrow_shift_unit_pkg.sv
// Shared definitions for the vector narrowing-shift unit.
// Provides `MAX_VLEN (default 512), the lane count, op/state enums and SEW codes.
`ifndef MAX_VLEN
`define MAX_VLEN 512
`endif

package vector_processor_defs;

  localparam int unsigned NSHIFT_VLEN  = `MAX_VLEN;
  localparam int unsigned NSHIFT_LANES = 4;

  typedef enum logic {
    NSRL = 1'b0,
    NSRA = 1'b1
  } nshift_op_e;

  typedef enum logic [1:0] {
    S_LO,
    S_HI,
    S_OUT
  } nshift_state_e;

  // Destination SEW encodings; any code with bit 1 set is illegal.
  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;

endpackage

// File: rtl/vector_narrow_shift_element.sv
// One narrowing-shift element: 2*SEW-bit source in, SEW-bit result out.
// SEW=8 uses src[15:0] and amt[3:0]; SEW=16 uses src[31:0] and amt[4:0].
module vector_narrow_shift_element
  import vector_processor_defs::*;
(
  input  logic [31:0] src_i,
  input  logic [4:0]  amt_i,
  input  nshift_op_e  op_i,
  input  logic [1:0]  sew_i,
  input  logic        round_i,
  output logic [15:0] res_o
);

  logic        sign;
  logic [32:0] ext;
  logic [4:0]  amt;
  logic [15:0] shifted;
  logic        rbit;

  // Sign/zero-extend the source to a common width, then shift arithmetically.
  always_comb begin
    if (sew_i == SEW_16) begin
      sign = (op_i == NSRA) & src_i[31];
      ext  = {sign, src_i};
      amt  = amt_i;
    end else begin
      sign = (op_i == NSRA) & src_i[15];
      ext  = {{17{sign}}, src_i[15:0]};
      amt  = {1'b0, amt_i[3:0]};
    end
    shifted = 16'($signed(ext) >>> amt);
    // Last bit shifted out drives round-to-nearest-up.
    rbit    = (amt != 5'd0) ? ext[amt - 5'd1] : 1'b0;
    res_o   = shifted + {15'd0, round_i & rbit};
  end

endmodule

// File: rtl/vector_narrow_shift_unit.sv
// Two-beat RVV narrowing shift (vnsrl/vnsra, vv/vx/vi).
// Beat 0 fills vd low half and captures control; beat 1 fills the high half.
// Optional rounding enabled by defining VNSHIFT_ROUND_EN (adds round_en_i).
module vector_narrow_shift_unit
  import vector_processor_defs::*;
#(
  parameter int unsigned VLEN  = `MAX_VLEN,
  parameter int unsigned LANES = NSHIFT_LANES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [VLEN-1:0] vs2_i,
  input  logic [VLEN-1:0] vs1_i,
  input  logic [31:0]     rs1_i,
  input  logic            use_scalar_i,
  input  logic            shift_op_i,
  input  logic [1:0]      sew_i,
`ifdef VNSHIFT_ROUND_EN
  input  logic            round_en_i,
`endif
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [VLEN-1:0] vd_o,
  output logic            err_o
);

  localparam int unsigned HalfW   = VLEN / 2;
  localparam int unsigned NumElem = VLEN / 16;
  localparam int unsigned NumWide = VLEN / 32;

  // Each 128-bit source lane must map onto a 64-bit slice of the half.
  if (LANES * 128 != VLEN) begin : g_lane_check
    $error("LANES must equal VLEN/128");
  end

  nshift_state_e   state_q, state_d;
  nshift_op_e      op_q;
  logic [1:0]      sew_q;
  logic            scal_q;
  logic [31:0]     rs1_q;
  logic [VLEN-1:0] vs1_q;
  logic [VLEN-1:0] vd_q;
  logic            out_valid_q;
  logic            err_q;
`ifdef VNSHIFT_ROUND_EN
  logic            round_q;
`endif

  logic            beat_acc;
  nshift_op_e      cur_op;
  logic [1:0]      cur_sew;
  logic            cur_sew16;
  logic            cur_scal;
  logic [31:0]     cur_rs1;
  logic [VLEN-1:0] cur_vs1;
  logic            cur_round;
  logic [HalfW-1:0] vs1_half;
  logic [HalfW-1:0] narrow;
  logic [15:0]     res [NumElem];

  assign beat_acc = in_valid_i && in_ready_o && !flush_i;

  // Beat 0 works from live inputs; beat 1 from the captured copy.
  always_comb begin
    if (state_q == S_LO) begin
      cur_op   = nshift_op_e'(shift_op_i);
      cur_sew  = sew_i;
      cur_scal = use_scalar_i;
      cur_rs1  = rs1_i;
      cur_vs1  = vs1_i;
    end else begin
      cur_op   = op_q;
      cur_sew  = sew_q;
      cur_scal = scal_q;
      cur_rs1  = rs1_q;
      cur_vs1  = vs1_q;
    end
`ifdef VNSHIFT_ROUND_EN
    cur_round = (state_q == S_LO) ? round_en_i : round_q;
`else
    cur_round = 1'b0;
`endif
    cur_sew16 = (cur_sew == SEW_16);
    vs1_half  = (state_q == S_HI) ? cur_vs1[VLEN-1 -: HalfW] : cur_vs1[HalfW-1:0];
  end

  for (genvar j = 0; j < NumElem; j++) begin : g_elem
    logic [31:0] src;
    logic [4:0]  amt_v;
    logic [4:0]  amt;
    if (j < NumWide) begin : g_wide
      assign src   = cur_sew16 ? vs2_i[j*32 +: 32] : {16'd0, vs2_i[j*16 +: 16]};
      assign amt_v = cur_sew16 ? vs1_half[j*16 +: 5] : vs1_half[j*8 +: 5];
    end else begin : g_narrow
      assign src   = {16'd0, vs2_i[j*16 +: 16]};
      assign amt_v = vs1_half[j*8 +: 5];
    end
    assign amt = cur_scal ? cur_rs1[4:0] : amt_v;

    vector_narrow_shift_element u_elem (
      .src_i   (src),
      .amt_i   (amt),
      .op_i    (cur_op),
      .sew_i   (cur_sew),
      .round_i (cur_round),
      .res_o   (res[j])
    );
  end

  // Pack element results into one vd half; illegal SEW yields zero.
  always_comb begin
    narrow = '0;
    if (cur_sew[1]) begin
      narrow = '0;
    end else if (cur_sew16) begin
      for (int j = 0; j < NumWide; j++) narrow[j*16 +: 16] = res[j];
    end else begin
      for (int j = 0; j < NumElem; j++) narrow[j*8 +: 8] = res[j][7:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_LO;
    else        state_q <= state_d;
  end

  // FSM next state; flush wins over everything.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_LO;
    end else begin
      unique case (state_q)
        S_LO:    if (beat_acc) state_d = S_HI;
        S_HI:    if (beat_acc) state_d = S_OUT;
        S_OUT:   if (out_ready_i) state_d = S_LO;
        default: state_d = S_LO;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    in_ready_o = (state_q != S_OUT);
  end

  // Control capture, result assembly and output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= NSRL;
      sew_q       <= 2'b00;
      scal_q      <= 1'b0;
      rs1_q       <= '0;
      vs1_q       <= '0;
      vd_q        <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef VNSHIFT_ROUND_EN
      round_q     <= 1'b0;
`endif
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (beat_acc && state_q == S_LO) begin
        op_q              <= cur_op;
        sew_q             <= sew_i;
        scal_q            <= use_scalar_i;
        rs1_q             <= rs1_i;
        vs1_q             <= vs1_i;
        vd_q[HalfW-1:0]   <= narrow;
`ifdef VNSHIFT_ROUND_EN
        round_q           <= round_en_i;
`endif
      end
      if (beat_acc && state_q == S_HI) begin
        vd_q[VLEN-1 -: HalfW] <= narrow;
        out_valid_q           <= 1'b1;
        err_q                 <= sew_q[1];
      end
      if (state_q == S_OUT && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign vd_o        = vd_q;
  assign out_valid_o = out_valid_q;
  assign err_o       = err_q;

endmodule
